seg_pair_capture: RTL

SEG_PAIR_CAPTURE -- requirements
Module: seg_pair_capture

---
 rtl/seg_pair_capture_if.sv | 21 ++
 rtl/seg_pair_capture.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg_pair_capture_if.sv
// Symbol-in / result-out handshake bundle for seg_pair_capture.
// The master drives symbols and data_ready; the slave (the capture block) answers.
interface seg_pair_capture_if;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic       seg_ready;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       err;

  modport master (
    output seg_in, seg_valid, data_ready,
    input  seg_ready, data, data_valid, err
  );

  modport slave (
    input  seg_in, seg_valid, data_ready,
    output seg_ready, data, data_valid, err
  );
endinterface

// File: rtl/seg_pair_capture.sv
// Rebuilds a 0..100 value from a tens/units pair of active-low 7-segment symbols,
// with a per-pair idle timeout and a one-cycle err pulse for discarded pairs.
module seg_pair_capture #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_pair_capture_if.slave bus
);

  localparam logic [1:0]  ST_TENS    = 2'd0;
  localparam logic [1:0]  ST_UNI     = 2'd1;
  localparam logic [1:0]  ST_HOLD    = 2'd2;
  localparam logic [3:0]  SYM_BLANK  = 4'd10;
  localparam logic [3:0]  SYM_INV    = 4'd15;
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  // Pattern to symbol code: 0..9 digits, 10 blank, 15 anything unrecognised.
  function automatic logic [3:0] decode_seg(input logic [6:0] pat);
    logic [3:0] sym;
    case (pat)
      7'b0000001: sym = 4'd0;
      7'b1001111: sym = 4'd1;
      7'b0010010: sym = 4'd2;
      7'b0000110: sym = 4'd3;
      7'b1001100: sym = 4'd4;
      7'b0100100: sym = 4'd5;
      7'b0100000: sym = 4'd6;
      7'b0001111: sym = 4'd7;
      7'b0000000: sym = 4'd8;
      7'b0000100: sym = 4'd9;
      7'b1111111: sym = SYM_BLANK;
      default:    sym = SYM_INV;
    endcase
    return sym;
  endfunction

  logic [1:0]  r_state;
  logic [3:0]  r_tens;
  logic [15:0] r_cnt;
  logic [7:0]  r_data;
  logic        r_data_valid;
  logic        r_err;

  logic [1:0]  w_next_state;
  logic [3:0]  w_next_tens;
  logic [15:0] w_next_cnt;
  logic [7:0]  w_next_data;
  logic        w_next_data_valid;
  logic        w_next_err;

  logic        w_seg_ready;
  logic        w_xfer;
  logic [3:0]  w_sym;
  logic [7:0]  w_sum;
  logic        w_tens_digit;
  logic        w_sym_digit;

  // Ready comes only from the state register, so there is no input-to-output path.
  assign w_seg_ready  = (r_state != ST_HOLD);
  assign w_xfer       = bus.seg_valid & w_seg_ready;
  assign w_sym        = decode_seg(bus.seg_in);
  assign w_tens_digit = (r_tens <= 4'd9);
  assign w_sym_digit  = (w_sym <= 4'd9);
  assign w_sum        = ({4'd0, r_tens} * 8'd10) + {4'd0, w_sym};

  // Next-state, data and err decision for the pair FSM.
  always_comb begin
    w_next_state      = r_state;
    w_next_tens       = r_tens;
    w_next_cnt        = r_cnt;
    w_next_data       = r_data;
    w_next_data_valid = r_data_valid;
    w_next_err        = 1'b0;
    case (r_state)
      ST_TENS: begin
        if (w_xfer) begin
          if (w_sym == SYM_INV) begin
            w_next_err = 1'b1;
          end else begin
            w_next_tens  = w_sym;
            w_next_cnt   = 16'd0;
            w_next_state = ST_UNI;
          end
        end else begin
          w_next_state = ST_TENS;
        end
      end
      ST_UNI: begin
        // A transfer beats a timeout that lands on the same edge.
        if (w_xfer) begin
          if (w_tens_digit && w_sym_digit) begin
            w_next_data       = w_sum;
            w_next_data_valid = 1'b1;
            w_next_state      = ST_HOLD;
          end else if ((r_tens == SYM_BLANK) && (w_sym == SYM_BLANK)) begin
            w_next_data       = 8'd100;
            w_next_data_valid = 1'b1;
            w_next_state      = ST_HOLD;
          end else begin
            w_next_err   = 1'b1;
            w_next_state = ST_TENS;
          end
        end else if (r_cnt == TIMEOUT_M1) begin
          w_next_err   = 1'b1;
          w_next_state = ST_TENS;
        end else begin
          w_next_cnt = r_cnt + 16'd1;
        end
      end
      ST_HOLD: begin
        if (bus.data_ready) begin
          w_next_data_valid = 1'b0;
          w_next_state      = ST_TENS;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: begin
        w_next_data_valid = 1'b0;
        w_next_state      = ST_TENS;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_TENS;
      r_tens       <= 4'd0;
      r_cnt        <= 16'd0;
      r_data       <= 8'd0;
      r_data_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_tens       <= w_next_tens;
      r_cnt        <= w_next_cnt;
      r_data       <= w_next_data;
      r_data_valid <= w_next_data_valid;
      r_err        <= w_next_err;
    end
  end

  assign bus.seg_ready  = w_seg_ready;
  assign bus.data       = r_data;
  assign bus.data_valid = r_data_valid;
  assign bus.err        = r_err;

endmodule
